lif_spike_monitor: RTL and testbench
====================================

LIF_SPIKE_MONITOR -- requirements
Module: lif_spike_monitor

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 24'd10_000_000: measurement window length in clk cycles; legal range 2..2^24-1.
REQ-002 SHALL have parameter ISI_WIDTH, default 16: width of the inter-spike-interval counter and output.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  monitor enable; low aborts and idles the monitor.
REQ-006 SHALL have port spike_in  input  1  spike level from the upstream LIF neuron, synchronous to clk, may stay high for several cycles.
REQ-007 SHALL have port rate_out  output  8  spike count of the last completed window.
REQ-008 SHALL have port rate_valid  output  1  one-cycle pulse marking a rate_out update.
REQ-009 SHALL have port overflow  output  1  set when the window reported in rate_out lost events to saturation.
REQ-010 SHALL have port isi_out  output  ISI_WIDTH  last inter-spike interval in cycles (ISI_MEASURE_EN only).
REQ-011 SHALL have port isi_valid  output  1  one-cycle pulse marking an isi_out update (ISI_MEASURE_EN only).

Function
REQ-012 SHALL register spike_in into spike_q every cycle regardless of state; event = spike_in & ~spike_q.
REQ-013 SHALL implement FSM states IDLE and COUNT; IDLE->COUNT on an edge with ena=1; COUNT->IDLE on an edge with ena=0; no other transitions.
REQ-014 In IDLE, the window counter and the event accumulator SHALL be 0, and events SHALL be ignored.
REQ-015 In COUNT, the window counter SHALL increment once per cycle from 0 to WINDOW_CYCLES-1, then wrap to 0.
REQ-016 In COUNT, each event SHALL increment the 8-bit accumulator, saturating at 255; an event at 255 SHALL set a window-overflow bit.
REQ-017 On the terminal cycle (counter = WINDOW_CYCLES-1), rate_out SHALL load the accumulator, including a same-cycle event with saturation, and overflow SHALL load the window-overflow bit, including a same-cycle saturated event.
REQ-018 On the same terminal cycle, rate_valid SHALL be high for exactly that one cycle after the edge, coincident with the new rate_out.
REQ-019 On the same terminal cycle, the accumulator and window-overflow bit SHALL clear; the next window starts at counter 0 with no gap cycle.
REQ-020 An event on the terminal cycle SHALL count in the closing window, never in the next one.
REQ-021 ena dropping mid-window SHALL discard the partial window: no rate_valid, rate_out and overflow retained, counter and accumulator cleared.
REQ-022 rate_out and overflow SHALL change only on a terminal cycle or on reset.

Reset
REQ-023 On rst=1, the block SHALL immediately set state=IDLE and clear spike_q, counter, accumulator, rate_out=0, rate_valid=0, overflow=0, isi_out=0, isi_valid=0, ISI counter=0 and have_ref=0.
REQ-024 Reset mid-window SHALL discard the window with no rate_valid pulse; operation SHALL resume on the first edge with rst=0 and ena=1.

Configuration
REQ-025 SHALL use macro LIF_SPIKE_MONITOR_ISI_MEASURE_EN.
REQ-026 With the macro defined, the ISI counter SHALL increment each COUNT cycle (saturating at all-ones) and load 1 on every event.
REQ-027 With the macro defined, an event with have_ref=1 SHALL load isi_out with the pre-load ISI counter value and pulse isi_valid once; the first event after entering COUNT SHALL set have_ref without a pulse.
REQ-028 With the macro defined, have_ref SHALL clear in IDLE, so consecutive events at cycles t1 and t2 report t2-t1.
REQ-029 With the macro undefined, isi_out and isi_valid SHALL be tied to 0, and no ISI registers SHALL exist; all other behaviour SHALL be identical.

Verification (WINDOW_CYCLES=16, ISI_WIDTH=16)
REQ-030 Scenario: rst pulse, ena=1, 3 single-cycle spikes within the window -> rate_valid once, 16 cycles after COUNT entry; rate_out=3; overflow=0.
REQ-031 Scenario: spike_in held high for 10 cycles -> one event; rate_out=1.
REQ-032 Scenario: WINDOW_CYCLES=600, spike_in toggling every cycle (300 events) -> rate_out=255, overflow=1; next quiet window -> rate_out=0, overflow=0.
REQ-033 Scenario: event on terminal cycle -> counted in the closing window (rate_out=1); following window reports 0.
REQ-034 Scenario: ena low at counter 9 with 2 events, then high -> no rate_valid for the aborted window; the next full window is reported alone.
REQ-035 Scenario (macro defined): events at COUNT cycles 2, 7, 27 -> isi_valid twice with isi_out=5 then 20; the first event produces no pulse.

Source files
------------

// File: rtl/lif_spike_monitor.sv
// Windowed spike-rate monitor for a LIF neuron output, with optional inter-spike-interval
// measurement enabled by defining LIF_SPIKE_MONITOR_ISI_MEASURE_EN.
module lif_spike_monitor #(
    parameter logic [23:0] WINDOW_CYCLES = 24'd10_000_000,
    parameter int          ISI_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 spike_in,
    output logic [7:0]           rate_out,
    output logic                 rate_valid,
    output logic                 overflow,
    output logic [ISI_WIDTH-1:0] isi_out,
    output logic                 isi_valid
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        spike_q;
    logic        event_s;
    logic        counting_s;
    logic        terminal_s;
    logic [23:0] cnt_r;
    logic [23:0] cnt_next_s;
    logic [7:0]  acc_r;
    logic [7:0]  acc_next_s;
    logic [7:0]  acc_sum_s;
    logic        wovf_r;
    logic        wovf_next_s;
    logic        wovf_sum_s;

    // Rising-edge detect plus saturating accumulation of the current event
    always_comb begin
        event_s    = spike_in & ~spike_q;
        counting_s = (state_r == COUNT) && ena;
        acc_sum_s  = acc_r;
        wovf_sum_s = wovf_r;
        if (event_s) begin
            if (acc_r == 8'd255) begin
                wovf_sum_s = 1'b1;
            end else begin
                acc_sum_s = acc_r + 8'd1;
            end
        end else begin
            acc_sum_s = acc_r;
        end
    end

    // Next-state logic for the window FSM, counter and accumulator
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        acc_next_s   = acc_r;
        wovf_next_s  = wovf_r;
        terminal_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_next_s  = 24'd0;
                acc_next_s  = 8'd0;
                wovf_next_s = 1'b0;
                if (ena) begin
                    state_next_s = COUNT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COUNT: begin
                if (!ena) begin
                    // Abort: the partial window is dropped without a report
                    state_next_s = IDLE;
                    cnt_next_s   = 24'd0;
                    acc_next_s   = 8'd0;
                    wovf_next_s  = 1'b0;
                end else if (cnt_r == (WINDOW_CYCLES - 24'd1)) begin
                    terminal_s  = 1'b1;
                    cnt_next_s  = 24'd0;
                    acc_next_s  = 8'd0;
                    wovf_next_s = 1'b0;
                end else begin
                    cnt_next_s  = cnt_r + 24'd1;
                    acc_next_s  = acc_sum_s;
                    wovf_next_s = wovf_sum_s;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 24'd0;
                acc_next_s   = 8'd0;
                wovf_next_s  = 1'b0;
            end
        endcase
    end

    // State, window bookkeeping and registered rate outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            spike_q    <= 1'b0;
            cnt_r      <= 24'd0;
            acc_r      <= 8'd0;
            wovf_r     <= 1'b0;
            rate_out   <= 8'd0;
            rate_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            spike_q    <= spike_in;
            cnt_r      <= cnt_next_s;
            acc_r      <= acc_next_s;
            wovf_r     <= wovf_next_s;
            rate_valid <= terminal_s;
            if (terminal_s) begin
                rate_out <= acc_sum_s;
                overflow <= wovf_sum_s;
            end else begin
                rate_out <= rate_out;
                overflow <= overflow;
            end
        end
    end

`ifdef LIF_SPIKE_MONITOR_ISI_MEASURE_EN
    logic [ISI_WIDTH-1:0] isi_cnt_r;
    logic                 have_ref;

    // Inter-spike interval: counter restarts at 1 on each event; first event only arms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt_r <= {ISI_WIDTH{1'b0}};
            have_ref  <= 1'b0;
            isi_out   <= {ISI_WIDTH{1'b0}};
            isi_valid <= 1'b0;
        end else if (counting_s) begin
            isi_valid <= event_s & have_ref;
            if (event_s) begin
                isi_cnt_r <= {{(ISI_WIDTH-1){1'b0}}, 1'b1};
                have_ref  <= 1'b1;
                if (have_ref) begin
                    isi_out <= isi_cnt_r;
                end else begin
                    isi_out <= isi_out;
                end
            end else if (isi_cnt_r != {ISI_WIDTH{1'b1}}) begin
                isi_cnt_r <= isi_cnt_r + {{(ISI_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                isi_cnt_r <= isi_cnt_r;
            end
        end else begin
            isi_cnt_r <= {ISI_WIDTH{1'b0}};
            have_ref  <= 1'b0;
            isi_valid <= 1'b0;
        end
    end
`else
    assign isi_out   = {ISI_WIDTH{1'b0}};
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed scoreboard bench for lif_spike_monitor: a 16-cycle window instance and a
// 600-cycle window instance for saturation.
module tb_lif_spike_monitor;

    logic        clk;
    logic        rst;
    logic        ena_a, spike_a, ena_b, spike_b;
    logic [7:0]  rate_out_a, rate_out_b;
    logic        rate_valid_a, rate_valid_b, overflow_a, overflow_b;
    logic [15:0] isi_out_a, isi_out_b;
    logic        isi_valid_a, isi_valid_b;

    int errors;
    int checks;
    int cyc;
    int c0, c1, c2, c3, cb;
    bit isi_chk;

    typedef struct {
        int rate;
        int ovf;
        int cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   qi[$];
    exp_t ea, eb;
    int   ei;

    lif_spike_monitor #(.WINDOW_CYCLES(24'd16), .ISI_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .ena(ena_a), .spike_in(spike_a),
        .rate_out(rate_out_a), .rate_valid(rate_valid_a), .overflow(overflow_a),
        .isi_out(isi_out_a), .isi_valid(isi_valid_a)
    );

    lif_spike_monitor #(.WINDOW_CYCLES(24'd600), .ISI_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .ena(ena_b), .spike_in(spike_b),
        .rate_out(rate_out_b), .rate_valid(rate_valid_b), .overflow(overflow_b),
        .isi_out(isi_out_b), .isi_valid(isi_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_n(input int base, input int n);
        for (int g = 0; g < 5000 && (cyc - base) < n; g++) step(1);
    endtask

    task automatic pulse_a();
        spike_a = 1'b1;
        step(1);
        spike_a = 1'b0;
    endtask

    // Scoreboard: pop expected window reports on each rate_valid pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (rate_valid_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_valid", {31'd0, rate_valid_a}, 32'd0);
                end else begin
                    ea = qa.pop_front();
                    chk("a_rate", {24'd0, rate_out_a}, ea.rate);
                    chk("a_ovf", {31'd0, overflow_a}, ea.ovf);
                    chk("a_cyc", cyc, ea.cyc);
                end
            end
            if (rate_valid_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_valid", {31'd0, rate_valid_b}, 32'd0);
                end else begin
                    eb = qb.pop_front();
                    chk("b_rate", {24'd0, rate_out_b}, eb.rate);
                    chk("b_ovf", {31'd0, overflow_b}, eb.ovf);
                    chk("b_cyc", cyc, eb.cyc);
                end
            end
`ifdef LIF_SPIKE_MONITOR_ISI_MEASURE_EN
            if (isi_chk && isi_valid_a) begin
                if (qi.size() == 0) begin
                    chk("isi_unexpected_valid", {31'd0, isi_valid_a}, 32'd0);
                end else begin
                    ei = qi.pop_front();
                    chk("isi_out", {16'd0, isi_out_a}, ei);
                end
            end
`else
            if (rate_valid_a) begin
                chk("isi_tied_zero", {15'd0, isi_valid_a, isi_out_a}, 32'd0);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1; ena_a = 1'b0; spike_a = 1'b0; ena_b = 1'b0; spike_b = 1'b0;
        errors = 0; checks = 0; cyc = 0; isi_chk = 1'b0;
        step(3);
        chk("rst_rate_out", {24'd0, rate_out_a}, 32'd0);
        chk("rst_rate_valid", {31'd0, rate_valid_a}, 32'd0);
        chk("rst_overflow", {31'd0, overflow_a}, 32'd0);
        chk("rst_isi", {15'd0, isi_valid_a, isi_out_a}, 32'd0);
        chk("rst_b_rate", {23'd0, overflow_b, rate_out_b}, 32'd0);
        rst = 1'b0;
        step(1);

        // Three single-cycle spikes, then a held spike, then a terminal-cycle spike
        ena_a = 1'b1;
        step(1);
        c0 = cyc;
        qa.push_back('{3, 0, c0 + 16});
        goto_n(c0, 2); pulse_a();
        goto_n(c0, 5); pulse_a();
        goto_n(c0, 9); pulse_a();
        qa.push_back('{1, 0, c0 + 32});
        goto_n(c0, 18); spike_a = 1'b1;
        goto_n(c0, 28); spike_a = 1'b0;
        qa.push_back('{1, 0, c0 + 48});
        qa.push_back('{0, 0, c0 + 64});
        goto_n(c0, 47); pulse_a();

        // Abort at counter 9 after two events
        goto_n(c0, 66); pulse_a();
        goto_n(c0, 70); pulse_a();
        goto_n(c0, 73); ena_a = 1'b0;
        step(2);
        chk("abort_q_empty", qa.size(), 32'd0);
        chk("abort_rate_kept", {24'd0, rate_out_a}, 32'd0);
        chk("abort_ovf_kept", {31'd0, overflow_a}, 32'd0);
        ena_a = 1'b1;
        step(1);
        c1 = cyc;
        qa.push_back('{4, 0, c1 + 16});
        goto_n(c1, 1); pulse_a();
        goto_n(c1, 4); pulse_a();
        goto_n(c1, 8); pulse_a();
        goto_n(c1, 15); pulse_a();
        step(2);
        chk("full_after_abort_q", qa.size(), 32'd0);
        chk("full_after_abort_rate", {24'd0, rate_out_a}, 32'd4);

        // Reset mid-window discards it; resume on first edge with rst low
        goto_n(c1, 18); pulse_a();
        goto_n(c1, 20); pulse_a();
        goto_n(c1, 22);
        rst = 1'b1;
        #1;
        chk("async_rst_rate", {24'd0, rate_out_a}, 32'd0);
        chk("async_rst_valid", {31'd0, rate_valid_a}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);
        c2 = cyc;
        qa.push_back('{2, 0, c2 + 16});
        goto_n(c2, 3); pulse_a();
        goto_n(c2, 10); pulse_a();
        goto_n(c2, 18);
        chk("post_rst_q", qa.size(), 32'd0);
        ena_a = 1'b0;
        step(20);
        chk("idle_rate_kept", {24'd0, rate_out_a}, 32'd2);

        // Interval segment: events at COUNT cycles 2, 7, 27
        ena_a = 1'b1;
        step(1);
        c3 = cyc;
`ifdef LIF_SPIKE_MONITOR_ISI_MEASURE_EN
        qi.push_back(5);
        qi.push_back(20);
`endif
        isi_chk = 1'b1;
        qa.push_back('{2, 0, c3 + 16});
        qa.push_back('{1, 0, c3 + 32});
        goto_n(c3, 2); pulse_a();
        goto_n(c3, 7); pulse_a();
        goto_n(c3, 27); pulse_a();
        goto_n(c3, 34);
        chk("isi_q_empty", qi.size(), 32'd0);
        ena_a = 1'b0;

        // Saturation: 300 events in a 600-cycle window, then a quiet window
        ena_b = 1'b1;
        step(1);
        cb = cyc;
        qb.push_back('{255, 1, cb + 600});
        qb.push_back('{0, 0, cb + 1200});
        for (int i = 0; i < 600; i++) begin
            spike_b = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
        end
        spike_b = 1'b0;
        goto_n(cb, 1203);

        for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) step(1);
        chk("final_qa_empty", qa.size(), 32'd0);
        chk("final_qb_empty", qb.size(), 32'd0);
        chk("final_b_ovf", {31'd0, overflow_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
